// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands are summed DIGIT bits per
// clock, LSB digit first, through a registered ripple carry.
module seq_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_add_sub: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, rs, rs_nxt;
    logic             cr, op_sub;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             cm;

    always_comb begin
        dsum   = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, cr};
        // carry into the digit's top bit, recovered from its sum and operands
        cm     = dsum[DIGIT-1] ^ sa[DIGIT-1] ^ sb[DIGIT-1];
        rs_nxt = (rs >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            rs       <= '0;
            cr       <= 1'b0;
            op_sub   <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa     <= a;
                        sb     <= sub ? ~b : b;
                        cr     <= sub;
                        op_sub <= sub;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    sa  <= sa >> DIGIT;
                    sb  <= sb >> DIGIT;
                    rs  <= rs_nxt;
                    cr  <= dsum[DIGIT];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state    <= DONE;
                        result   <= rs_nxt;
                        carry    <= op_sub ? ~dsum[DIGIT] : dsum[DIGIT];
                        overflow <= cm ^ dsum[DIGIT];
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboarded bench: one WIDTH=8/DIGIT=1 instance for directed cases plus
// three randomized instances covering the (8,4), (8,8) and (16,4) configurations.
module tb_seq_add_sub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0, nfail = 0, ndone = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- directed instance ----------------
    logic       d_rst, d_iv, d_ir, d_sub, d_ov, d_ordy, d_c, d_o, d_bz;
    logic [7:0] d_a, d_b, d_r;
    logic [9:0] dq[$];
    logic [9:0] d_e;
    int         d_cyc = 0, d_acc = 0;
    logic       d_pov = 1'b0;

    seq_add_sub #(.WIDTH(8), .DIGIT(1)) u_d (
        .clk(clk), .rst_n(d_rst), .in_valid(d_iv), .in_ready(d_ir),
        .a(d_a), .b(d_b), .sub(d_sub), .out_valid(d_ov), .out_ready(d_ordy),
        .result(d_r), .carry(d_c), .overflow(d_o), .busy(d_bz)
    );

    always @(posedge clk) d_cyc <= d_cyc + 1;

    always @(negedge clk) begin
        if (d_ov && !d_pov) chk("d_latency", d_cyc - d_acc, 8);
        if (d_ov && d_ordy) begin
            if (dq.size() == 0) chk("d_unexpected_output", 1, 0);
            else begin
                d_e = dq.pop_front();
                chk("d_result", d_r, d_e[9:2]);
                chk("d_carry", d_c, d_e[1]);
                chk("d_overflow", d_o, d_e[0]);
            end
        end
        d_pov = d_ov;
    end

    task automatic d_tick();
        @(posedge clk); #1;
    endtask

    task automatic d_accept(input logic [7:0] x, input logic [7:0] y, input logic s,
                            input logic [7:0] er, input logic ec, input logic eo);
        int k = 0;
        d_a = x; d_b = y; d_sub = s; d_iv = 1'b1;
        while (!d_ir && k < 50) begin d_tick(); k++; end
        if (!d_ir) chk("d_accept_timeout", 0, 1);
        dq.push_back({er, ec, eo});
        d_tick();
        d_acc = d_cyc;
        d_iv  = 1'b0;
        chk("d_busy_after_accept", d_bz, 1);
        chk("d_in_ready_after_accept", d_ir, 0);
    endtask

    task automatic d_drain();
        int k = 0;
        while (dq.size() != 0 && k < 100) begin d_tick(); k++; end
        if (dq.size() != 0) chk("d_drain_timeout", dq.size(), 0);
        d_tick();
    endtask

    initial begin
        logic [7:0] hr;
        logic       hc, ho;
        int         k;
        d_rst = 1'b0; d_iv = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_ordy = 1'b1;
        #12;
        chk("rst_out_valid", d_ov, 0);
        chk("rst_busy", d_bz, 0);
        chk("rst_result", d_r, 0);
        chk("rst_carry", d_c, 0);
        chk("rst_overflow", d_o, 0);
        d_tick();
        d_rst = 1'b1;
        chk("rst_in_ready", d_ir, 1);

        d_accept(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1); d_drain();
        d_accept(8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0); d_drain();
        d_accept(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); d_drain();
        d_accept(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1); d_drain();

        // backpressure: stall in DONE while a new request is offered
        d_ordy = 1'b0;
        d_accept(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
        k = 0;
        while (!d_ov && k < 50) begin d_tick(); k++; end
        chk("bp_reached_done", d_ov, 1);
        hr = d_r; hc = d_c; ho = d_o;
        d_a = 8'h7F; d_b = 8'h01; d_sub = 1'b0; d_iv = 1'b1;
        repeat (5) begin
            d_tick();
            chk("bp_result_stable", d_r, hr);
            chk("bp_flags_stable", {d_c, d_o}, {hc, ho});
            chk("bp_out_valid_held", d_ov, 1);
            chk("bp_in_ready_low", d_ir, 0);
        end
        dq.push_back({8'h80, 1'b0, 1'b1});
        d_ordy = 1'b1;
        k = 0;
        while (!d_ir && k < 50) begin d_tick(); k++; end
        chk("bp_ready_after_pop", d_ir, 1);
        d_tick();
        d_acc = d_cyc;
        d_iv  = 1'b0;
        d_drain();

        // reset during CALC step 3
        d_accept(8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0);
        repeat (2) d_tick();
        d_rst = 1'b0;
        dq.delete();
        #1;
        chk("midrst_out_valid", d_ov, 0);
        chk("midrst_busy", d_bz, 0);
        chk("midrst_result", d_r, 0);
        chk("midrst_flags", {d_c, d_o}, 2'b00);
        d_tick();
        d_rst = 1'b1;
        chk("midrst_in_ready", d_ir, 1);
        d_accept(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        d_drain();
        ndone++;
    end

    // ---------------- randomized parameter sweep ----------------
    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = (g == 2) ? 16 : 8;
        localparam int D = (g == 1) ? 8 : 4;
        localparam int N = W / D;

        logic         rst_n, iv, ir, s, ov, c, o, bz;
        logic         ordy = 1'b1;
        logic [W-1:0] a, b, r;
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        int           cyc = 0, acc = 0;
        logic         pov = 1'b0;

        seq_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(a), .b(b), .sub(s), .out_valid(ov), .out_ready(ordy),
            .result(r), .carry(c), .overflow(o), .busy(bz)
        );

        // plain integer arithmetic: wrapped result, carry/borrow, signed range check
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sb);
            longint ux, uy, sx, sy, sr, lim;
            logic [W-1:0] rr;
            logic cc, oo;
            ux  = longint'(x);
            uy  = longint'(y);
            lim = longint'(1) << (W - 1);
            sx  = (ux >= lim) ? ux - 2 * lim : ux;
            sy  = (uy >= lim) ? uy - 2 * lim : uy;
            if (sb) begin
                rr = W'(ux - uy); cc = (ux < uy); sr = sx - sy;
            end else begin
                rr = W'(ux + uy); cc = ((ux + uy) >= 2 * lim); sr = sx + sy;
            end
            oo = (sr >= lim) || (sr < -lim);
            return {rr, cc, oo};
        endfunction

        always @(posedge clk) cyc <= cyc + 1;

        always @(negedge clk) begin
            ordy = ($urandom % 4) != 0;
            if (ov && !pov) chk($sformatf("sweep%0d_latency", g), cyc - acc, N);
            if (ov && ordy) begin
                if (q.size() == 0) chk($sformatf("sweep%0d_unexpected_output", g), 1, 0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("sweep%0d_result", g), 32'(r), 32'(e[W+1:2]));
                    chk($sformatf("sweep%0d_carry", g), c, e[1]);
                    chk($sformatf("sweep%0d_overflow", g), o, e[0]);
                end
            end
            pov = ov;
        end

        initial begin
            int k;
            rst_n = 1'b0; iv = 1'b0; a = '0; b = '0; s = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                a = W'($urandom); b = W'($urandom); s = 1'($urandom); iv = 1'b1;
                k = 0;
                while (!ir && k < 50) begin @(posedge clk); #1; k++; end
                if (!ir) chk($sformatf("sweep%0d_accept_timeout", g), 0, 1);
                q.push_back(model(a, b, s));
                @(posedge clk); #1;
                acc = cyc;
                // junk presented while busy must be ignored
                iv = 1'($urandom); a = W'($urandom); b = W'($urandom); s = 1'($urandom);
                k = 0;
                while (!ir && k < 50) begin @(posedge clk); #1; k++; end
                iv = 1'b0;
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
            k = 0;
            while (q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
            if (q.size() != 0) chk($sformatf("sweep%0d_drain_timeout", g), q.size(), 0);
            ndone++;
        end
    end

    initial begin
        int t = 0;
        while (ndone < 4 && t < 60000) begin @(posedge clk); t++; end
        if (ndone < 4) chk("completion_timeout", ndone, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
